input_vc_ctrl_fsm: RTL

Parametrised, FSM-based input VC controller for one input VC of a wormhole router with N ports and V VCs per port. It sequences each packet through route computation (RC), VC allocation (VA) and switch allocation (SA), and holds the route and VC for the packet's lifetime. It drives the pop of its input FIFO. It adds three things over the fixed 5-port controller: single-flit packets, protocol-error detection, and a per-packet flit counter.

---
 rtl/input_vc_ctrl_fsm.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/input_vc_ctrl_fsm.sv
// Input VC controller for one VC of an N-port wormhole router: sequences each
// packet through RC, VA and SA, holds route/VC for the packet and pops the FIFO.
module input_vc_ctrl_fsm #(
    parameter int DW    = 32,
    parameter int N     = 5,
    parameter int V     = 4,
    parameter int DST_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [DW-1:0]    flit_data,
    input  logic             flit_valid,
    output logic             flit_pop,
    output logic [DST_W-1:0] rc_dst,
    output logic             rc_valid,
    input  logic [N-1:0]     rc_port,
    input  logic [V-1:0]     rc_vc_mask,
    output logic             va_req,
    output logic [N-1:0]     va_port,
    output logic [V-1:0]     va_vc_mask,
    input  logic             va_grant,
    input  logic [V-1:0]     va_vc,
    output logic [N-1:0]     sa_req,
    input  logic             sa_grant,
    output logic [V-1:0]     out_vc,
    input  logic [N*V-1:0]   vc_ready_all,
    output logic [CNT_W-1:0] flit_cnt,
    output logic [1:0]       state_o,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_VA     = 2'd1,
        S_ACTIVE = 2'd2,
        S_UNUSED = 2'd3
    } state_e;

    localparam logic [1:0]       T_HEAD   = 2'b10;
    localparam logic [1:0]       T_TAIL   = 2'b01;
    localparam logic [1:0]       T_SINGLE = 2'b11;
    localparam logic [V-1:0]     V_ONE    = {{(V-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [N-1:0]     out_port_q, out_port_d;
    logic [V-1:0]     vc_mask_q, vc_mask_d;
    logic [V-1:0]     out_vc_q, out_vc_d;
    logic [CNT_W-1:0] flit_cnt_q, flit_cnt_d;

    logic [1:0] flit_type;
    logic       is_head, is_single, is_tail;
    logic       rdy;
    logic       va_vc_onehot;
    logic       unused_flit_bits;

    assign flit_type        = flit_data[DW-1:DW-2];
    assign is_head          = (flit_type == T_HEAD);
    assign is_single        = (flit_type == T_SINGLE);
    assign is_tail          = (flit_type == T_TAIL);
    assign rc_dst           = flit_data[DST_W-1:0];
    assign va_vc_onehot     = (va_vc != '0) && ((va_vc & (va_vc - V_ONE)) == '0);
    assign unused_flit_bits = ^flit_data[DW-3:DST_W];

    assign state_o  = state_q;
    assign out_vc   = out_vc_q;
    assign flit_cnt = flit_cnt_q;

    // Downstream readiness of the held VC on the held port only.
    always_comb begin
        rdy = 1'b0;
        for (int p = 0; p < N; p++) begin
            if (out_port_q[p] && ((vc_ready_all[p*V +: V] & out_vc_q) != '0)) begin
                rdy = 1'b1;
            end
        end
    end

    always_comb begin
        // NOTE: every output and next-state signal gets a default first so no latch is inferred.
        state_d    = state_q;
        out_port_d = out_port_q;
        vc_mask_d  = vc_mask_q;
        out_vc_d   = out_vc_q;
        flit_cnt_d = flit_cnt_q;
        rc_valid   = 1'b0;
        va_req     = 1'b0;
        va_port    = '0;
        va_vc_mask = '0;
        sa_req     = '0;
        flit_pop   = 1'b0;
        err        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (flit_valid) begin
                    if (is_head || is_single) begin
                        rc_valid   = 1'b1;
                        out_port_d = rc_port;
                        vc_mask_d  = rc_vc_mask;
                        state_d    = S_VA;
                    end else begin
                        flit_pop = 1'b1;
                        err      = 1'b1;
                    end
                end
            end
            S_VA: begin
                va_req     = 1'b1;
                va_port    = out_port_q;
                va_vc_mask = vc_mask_q;
                if (va_grant) begin
                    if (va_vc_onehot) begin
                        out_vc_d = va_vc;
                        state_d  = S_ACTIVE;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            S_ACTIVE: begin
                if (flit_valid && rdy) begin
                    sa_req = out_port_q;
                end
                // The packet's own head is still queued while the count is zero;
                // any later HEAD is a stray and is forwarded as a body flit.
                if (flit_valid && is_head && (flit_cnt_q != '0)) begin
                    err = 1'b1;
                end
                if (sa_grant && (sa_req != '0)) begin
                    flit_pop   = 1'b1;
                    flit_cnt_d = (&flit_cnt_q) ? flit_cnt_q : flit_cnt_q + CNT_ONE;
                    if (is_tail || is_single) begin
                        state_d    = S_IDLE;
                        out_vc_d   = '0;
                        out_port_d = '0;
                        flit_cnt_d = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Nothing may be requested or popped while reset is held.
        if (!rstn) begin
            rc_valid   = 1'b0;
            va_req     = 1'b0;
            va_port    = '0;
            va_vc_mask = '0;
            sa_req     = '0;
            flit_pop   = 1'b0;
            err        = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            out_port_q <= '0;
            vc_mask_q  <= '0;
            out_vc_q   <= '0;
            flit_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            out_port_q <= out_port_d;
            vc_mask_q  <= vc_mask_d;
            out_vc_q   <= out_vc_d;
            flit_cnt_q <= flit_cnt_d;
        end
    end

endmodule
